// File: rtl/mem_bus_arbiter_if.sv
// Two-master / one-memory bus bundle for mem_bus_arbiter.
// Combinational request path; read data returns one cycle after a read enable.
// Masters hold a request until ready; the arbiter never latches requests.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  // master 0 (cpu core)
  logic              m0_enable;
  logic [3:0]        m0_wstrb;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wvalue;
  logic              m0_ready;
  logic              m0_rvalid;
  logic [31:0]       m0_rvalue;
  // master 1 (debug / DMA)
  logic              m1_enable;
  logic [3:0]        m1_wstrb;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wvalue;
  logic              m1_ready;
  logic              m1_rvalid;
  logic [31:0]       m1_rvalue;
  // single-port memory
  logic              mem_enable;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wvalue;
  logic [31:0]       mem_rvalue;

  // arbiter side
  modport slave (
    input  m0_enable, m0_wstrb, m0_addr, m0_wvalue,
    output m0_ready, m0_rvalid, m0_rvalue,
    input  m1_enable, m1_wstrb, m1_addr, m1_wvalue,
    output m1_ready, m1_rvalid, m1_rvalue,
    output mem_enable, mem_wstrb, mem_addr, mem_wvalue,
    input  mem_rvalue
  );

  // masters + memory side
  modport master (
    output m0_enable, m0_wstrb, m0_addr, m0_wvalue,
    input  m0_ready, m0_rvalid, m0_rvalue,
    output m1_enable, m1_wstrb, m1_addr, m1_wvalue,
    input  m1_ready, m1_rvalid, m1_rvalue,
    input  mem_enable, mem_wstrb, mem_addr, mem_wvalue,
    output mem_rvalue
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between two masters (round-robin or fixed priority with anti-starvation).
// Latency: grant and forward in the same cycle; read data steered back one cycle later.
// Backpressure: loser sees ready=0 and must hold its request; withdrawn requests are simply ignored.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int RR_MODE    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_M0   = 2'd1,
    TAG_M1   = 2'd2
  } tag_e;

  logic              prio_q, prio_d;       // RR: 1 means m1 preferred
  logic [3:0]        starve_cnt, starve_d; // fixed: consecutive cycles m1 lost
  tag_e              resp_tag, resp_tag_d; // who owns next cycle's read data
  logic              m1_forced;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] addr_sel;

  // state register: priority pointer, starvation counter, response tag
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prio_q     <= 1'b0;
      starve_cnt <= 4'd0;
      resp_tag   <= TAG_NONE;
    end else begin
      prio_q     <= prio_d;
      starve_cnt <= starve_d;
      resp_tag   <= resp_tag_d;
    end
  end

  // grant decision from registered state and current requests; nothing granted in reset
  always_comb begin
    m1_forced = (RR_MODE != 0) ? prio_q : (starve_cnt == STARVE_LIM);
    gnt0      = rstn_i && bus.m0_enable && (!bus.m1_enable || !m1_forced);
    gnt1      = rstn_i && bus.m1_enable && (!bus.m0_enable || m1_forced);
  end

  // next-state: flip priority after each grant, count m1 losses, tag granted reads
  always_comb begin
    prio_d     = prio_q;
    starve_d   = 4'd0;
    resp_tag_d = TAG_NONE;
    if (RR_MODE != 0) begin
      if (gnt0)      prio_d = 1'b1;
      else if (gnt1) prio_d = 1'b0;
    end else if (bus.m1_enable && !gnt1) begin
      starve_d = (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
    end
    if (gnt0 && bus.m0_wstrb == 4'd0)      resp_tag_d = TAG_M0;
    else if (gnt1 && bus.m1_wstrb == 4'd0) resp_tag_d = TAG_M1;
  end

  // outputs: forward the winner to memory, steer read data by tag, all zero in reset
  always_comb begin
    addr_sel       = gnt0 ? bus.m0_addr : (gnt1 ? bus.m1_addr : '0);
    bus.mem_enable = gnt0 | gnt1;
    bus.mem_wstrb  = gnt0 ? bus.m0_wstrb  : (gnt1 ? bus.m1_wstrb  : 4'd0);
    bus.mem_wvalue = gnt0 ? bus.m0_wvalue : (gnt1 ? bus.m1_wvalue : 32'd0);
    bus.mem_addr   = addr_sel;
    bus.m0_ready   = gnt0;
    bus.m1_ready   = gnt1;
    bus.m0_rvalid  = rstn_i && (resp_tag == TAG_M0);
    bus.m1_rvalid  = rstn_i && (resp_tag == TAG_M1);
    bus.m0_rvalue  = bus.m0_rvalid ? bus.mem_rvalue : 32'd0;
    bus.m1_rvalue  = bus.m1_rvalid ? bus.mem_rvalue : 32'd0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority instance share stimulus.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Memory model returns {addr[15:0],16'hA5A5} the cycle after a read, 32'hBAD0BAD0 otherwise.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32)) rr ();
  mem_bus_arbiter_if #(.ADDR_W(32)) fx ();

  mem_bus_arbiter #(.ADDR_W(32), .RR_MODE(1), .STARVE_MAX(4)) u_rr (
    .clk_i(clk), .rstn_i(rstn), .bus(rr.slave));
  mem_bus_arbiter #(.ADDR_W(32), .RR_MODE(0), .STARVE_MAX(4)) u_fx (
    .clk_i(clk), .rstn_i(rstn), .bus(fx.slave));

  // memory models
  always @(posedge clk)
    rr.mem_rvalue <= (rr.mem_enable && rr.mem_wstrb == 4'd0) ? {rr.mem_addr[15:0], 16'hA5A5} : 32'hBAD0BAD0;
  always @(posedge clk)
    fx.mem_rvalue <= (fx.mem_enable && fx.mem_wstrb == 4'd0) ? {fx.mem_addr[15:0], 16'hA5A5} : 32'hBAD0BAD0;

  task automatic drive(input logic e0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
    rr.m0_enable = e0; rr.m0_wstrb = w0; rr.m0_addr = a0; rr.m0_wvalue = d0;
    rr.m1_enable = e1; rr.m1_wstrb = w1; rr.m1_addr = a1; rr.m1_wvalue = d1;
    fx.m0_enable = e0; fx.m0_wstrb = w0; fx.m0_addr = a0; fx.m0_wvalue = d0;
    fx.m1_enable = e1; fx.m1_wstrb = w1; fx.m1_addr = a1; fx.m1_wvalue = d1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b1, 4'd0, 32'h100, 32'h1111, 1'b1, 4'd0, 32'h200, 32'h2222);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rr.mem_enable, rr.mem_wstrb, rr.mem_addr, rr.mem_wvalue, rr.m0_ready, rr.m1_ready,
           rr.m0_rvalid, rr.m1_rvalid, rr.m0_rvalue, rr.m1_rvalue} !== '0)
        $display("FAIL reset_outputs_rr cycle %0d: mem_en=%b addr=%h rdy=%b%b", k,
                 rr.mem_enable, rr.mem_addr, rr.m0_ready, rr.m1_ready);
      else passed++;
      checks++;
      if ({fx.mem_enable, fx.mem_wstrb, fx.mem_addr, fx.mem_wvalue, fx.m0_ready, fx.m1_ready,
           fx.m0_rvalid, fx.m1_rvalid, fx.m0_rvalue, fx.m1_rvalue} !== '0)
        $display("FAIL reset_outputs_fx cycle %0d: mem_en=%b addr=%h rdy=%b%b", k,
                 fx.mem_enable, fx.mem_addr, fx.m0_ready, fx.m1_ready);
      else passed++;
      next_cycle();
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({rr.m0_ready, rr.m1_ready, rr.mem_addr} !== {1'b1, 1'b0, 32'h100})
      $display("FAIL reset_first_grant: rdy=%b%b addr=%h, want rdy=10 addr=00000100",
               rr.m0_ready, rr.m1_ready, rr.mem_addr);
    else passed++;
    next_cycle();
    idle();
  endtask

  task automatic test_rr_reads();
    logic [31:0] exp_data;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 4'd0, 32'h100, 32'd0, 1'b1, 4'd0, 32'h200, 32'd0);
      else idle();
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if ({rr.m0_ready, rr.m1_ready, rr.mem_enable, rr.mem_addr} !==
            {(k % 2) == 0, (k % 2) == 1, 1'b1, ((k % 2) == 1) ? 32'h200 : 32'h100})
          $display("FAIL rr_grant cycle %0d: rdy=%b%b addr=%h", k, rr.m0_ready, rr.m1_ready, rr.mem_addr);
        else passed++;
      end
      if (k > 0) begin
        exp_data = ((k - 1) % 2 == 1) ? 32'h0200A5A5 : 32'h0100A5A5;
        checks++;
        if ({rr.m0_rvalid, rr.m1_rvalid} !== {(k - 1) % 2 == 0, (k - 1) % 2 == 1})
          $display("FAIL rr_rvalid cycle %0d: rvalid=%b%b", k, rr.m0_rvalid, rr.m1_rvalid);
        else passed++;
        checks++;
        if (((k - 1) % 2 == 1) ? ({rr.m1_rvalue, rr.m0_rvalue} !== {exp_data, 32'd0})
                               : ({rr.m0_rvalue, rr.m1_rvalue} !== {exp_data, 32'd0}))
          $display("FAIL rr_rvalue cycle %0d: m0=%h m1=%h want %h at issuer", k,
                   rr.m0_rvalue, rr.m1_rvalue, exp_data);
        else passed++;
      end
      next_cycle();
    end
  endtask

  task automatic test_fixed_starve();
    do_reset();
    drive(1'b1, 4'd0, 32'h100, 32'd0, 1'b1, 4'd0, 32'h200, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({fx.m0_ready, fx.m1_ready} !== {(k % 5) != 4, (k % 5) == 4})
        $display("FAIL fixed_starve cycle %0d: rdy=%b%b want m1=%b", k,
                 fx.m0_ready, fx.m1_ready, (k % 5) == 4);
      else passed++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_write_then_read();
    do_reset();
    drive(1'b1, 4'b0011, 32'h10, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if ({rr.m0_ready, rr.mem_enable, rr.mem_wstrb, rr.mem_addr, rr.mem_wvalue} !==
        {1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEADBEEF})
      $display("FAIL wr_forward: rdy=%b wstrb=%b addr=%h data=%h", rr.m0_ready,
               rr.mem_wstrb, rr.mem_addr, rr.mem_wvalue);
    else passed++;
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h10, 32'd0);
    @(negedge clk);
    checks++;
    if ({rr.m1_ready, rr.m0_rvalid, rr.m1_rvalid} !== 3'b100)
      $display("FAIL wr_no_resp: m1_ready=%b rvalid=%b%b want 1,00", rr.m1_ready, rr.m0_rvalid, rr.m1_rvalid);
    else passed++;
    next_cycle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b1010, 32'h24, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({rr.m0_rvalid, rr.m1_rvalid, rr.m1_rvalue} !== {2'b01, 32'h0010A5A5})
      $display("FAIL rd_after_wr: rvalid=%b%b m1_rvalue=%h want 01,0010a5a5",
               rr.m0_rvalid, rr.m1_rvalid, rr.m1_rvalue);
    else passed++;
    checks++;
    if ({rr.mem_wstrb, rr.mem_addr, rr.mem_wvalue} !== {4'b1010, 32'h24, 32'h12345678})
      $display("FAIL wstrb_noncontig: wstrb=%b addr=%h data=%h", rr.mem_wstrb, rr.mem_addr, rr.mem_wvalue);
    else passed++;
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({rr.m0_rvalid, rr.m1_rvalid} !== 2'b00)
      $display("FAIL wr_no_rvalid: rvalid=%b%b want 00", rr.m0_rvalid, rr.m1_rvalid);
    else passed++;
    next_cycle();
  endtask

  task automatic test_reset_during_read();
    do_reset();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h40, 32'd0);
    @(negedge clk);
    checks++;
    if (rr.m1_ready !== 1'b1)
      $display("FAIL rst_rd_grant: m1_ready=%b want 1", rr.m1_ready);
    else passed++;
    next_cycle();
    rstn = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({rr.m1_rvalid, rr.m1_rvalue, fx.m1_rvalid} !== {1'b0, 32'd0, 1'b0})
      $display("FAIL rst_rd_rvalid: rr=%b/%h fx=%b want 0", rr.m1_rvalid, rr.m1_rvalue, fx.m1_rvalid);
    else passed++;
    next_cycle();
    rstn = 1'b1;
    drive(1'b1, 4'd0, 32'h100, 32'd0, 1'b1, 4'd0, 32'h200, 32'd0);
    @(negedge clk);
    checks++;
    if ({rr.m0_ready, rr.m1_ready, rr.m1_rvalid} !== 3'b100)
      $display("FAIL rst_prio_clear: rdy=%b%b m1_rvalid=%b want 10,0", rr.m0_ready, rr.m1_ready, rr.m1_rvalid);
    else passed++;
    next_cycle();
    for (int k = 0; k < 2; k++) next_cycle();
    rstn = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({fx.m0_ready, fx.m1_ready} !== {k != 4, k == 4})
        $display("FAIL rst_starve_clear cycle %0d: rdy=%b%b", k, fx.m0_ready, fx.m1_ready);
      else passed++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_lone_m1();
    do_reset();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 32'h300, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({rr.m0_ready, rr.m1_ready, rr.mem_addr} !== {2'b01, 32'h300})
        $display("FAIL lone_m1 cycle %0d: rdy=%b%b addr=%h", k, rr.m0_ready, rr.m1_ready, rr.mem_addr);
      else passed++;
      if (k > 0) begin
        checks++;
        if ({rr.m1_rvalid, rr.m1_rvalue} !== {1'b1, 32'h0300A5A5})
          $display("FAIL lone_m1_data cycle %0d: rvalid=%b rvalue=%h", k, rr.m1_rvalid, rr.m1_rvalue);
        else passed++;
      end
      next_cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_rr_reads();
    test_fixed_starve();
    test_write_then_read();
    test_reset_during_read();
    test_lone_m1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
